// File: rtl/button_event_decoder_pkg.sv
// Shared button-event constants: FSM state encoding, counter widths and the
// event pulse bundle used by the decoder and any board FSM that consumes it.
package button_event_decoder_pkg;

    localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
    localparam logic [1:0] ST_PRESSED_ENC = 2'd1;
    localparam logic [1:0] ST_REPEAT_ENC  = 2'd2;

    localparam int PRESS_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_PRESSED = ST_PRESSED_ENC,
        ST_REPEAT  = ST_REPEAT_ENC
    } btn_state_e;

    // One-cycle event pulses; at most one bit is set in any cycle.
    typedef struct packed {
        logic press;
        logic rel;
        logic lng;
        logic rpt;
    } btn_events_t;

    localparam btn_events_t EV_NONE = '{press: 1'b0, rel: 1'b0, lng: 1'b0, rpt: 1'b0};

endpackage

// File: rtl/button_event_if.sv
// Button event bus: debounced level in, decoded events and press count out.
interface button_event_if;
    import button_event_decoder_pkg::*;

    logic                   clean;
    logic                   press_pulse;
    logic                   release_pulse;
    logic                   long_pulse;
    logic                   repeat_pulse;
    logic                   held;
    logic [PRESS_CNT_W-1:0] press_count;

    modport master (
        input  clean,
        output press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_count
    );

    modport slave (
        output clean,
        input  press_pulse, release_pulse, long_pulse, repeat_pulse, held, press_count
    );

endinterface

// File: rtl/button_event_decoder_edge.sv
// Registers a level and reports its rising/falling transitions against the
// registered copy; reset clears the copy so a level already high reads as a rise.
module level_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic in_q_o,
    output logic rise_o,
    output logic fall_o
);

    logic in_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_i;
        end
    end

    assign in_q_o = in_q;
    assign rise_o = in_i & ~in_q;
    assign fall_o = ~in_i & in_q;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/long/repeat pulses plus a
// wrapping press count. All outputs are registered.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int LONG_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic          clk,
    input  logic          rst,
    button_event_if.master bus
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic clean_q, rise, fall, hold;

    level_edge_detect u_edge (
        .clk    (clk),
        .rst    (rst),
        .in_i   (bus.clean),
        .in_q_o (clean_q),
        .rise_o (rise),
        .fall_o (fall)
    );

    // Button still down this cycle and last cycle: the hold timer may advance.
    assign hold = bus.clean & clean_q;

    btn_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    btn_events_t            ev_q, ev_d;
    logic                   held_q, held_d;
    logic [PRESS_CNT_W-1:0] count_q, count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ev_q    <= EV_NONE;
            held_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ev_q    <= ev_d;
            held_q  <= held_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ev_d    = EV_NONE;
        count_d = count_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    ev_d.press = 1'b1;
                    count_d    = count_q + PRESS_CNT_W'(1);
                    state_d    = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                // Release is tested first so it wins over a terminal count.
                if (fall) begin
                    ev_d.rel = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else if (hold) begin
                    if (cnt_q == LONG_LAST) begin
                        ev_d.lng = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_REPEAT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_REPEAT: begin
                if (fall) begin
                    ev_d.rel = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else if (hold) begin
                    if (cnt_q == RPT_LAST) begin
                        ev_d.rpt = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        held_d = (state_d != ST_IDLE);
    end

    assign bus.press_pulse   = ev_q.press;
    assign bus.release_pulse = ev_q.rel;
    assign bus.long_pulse    = ev_q.lng;
    assign bus.repeat_pulse  = ev_q.rpt;
    assign bus.held          = held_q;
    assign bus.press_count   = count_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder: an edge-timeline model checked every
// cycle, plus literal event-timing checks for each scenario.
module tb_button_event_decoder;

    localparam int LONG = 16;
    localparam int RPT  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    button_event_if bus ();

    button_event_decoder #(
        .LONG_CYCLES   (LONG),
        .REPEAT_CYCLES (RPT),
        .CNT_W         (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model: pressed flag, edge of the press, wrapped count, expected pulses
    bit m_pressed = 1'b0;
    int m_pedge   = 0;
    int m_count   = 0;
    bit m_p, m_r, m_l, m_rp, m_h;

    // events observed on the DUT
    int n_press = 0, n_rel = 0, n_long = 0, n_rep = 0;
    int press_e = 0, rel_e = 0, long_e = 0;
    int rep_q[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic c, input logic r);
        int d;
        logic [12:0] act, exp;
        @(negedge clk);
        bus.clean = c;
        rst       = r;
        @(posedge clk);
        cyc++;
        {m_p, m_r, m_l, m_rp} = 4'b0;
        if (r) begin
            m_pressed = 1'b0;
            m_count   = 0;
        end else if (!m_pressed) begin
            if (c) begin
                m_p       = 1'b1;
                m_pressed = 1'b1;
                m_pedge   = cyc;
                m_count   = (m_count + 1) % 256;
            end
        end else if (!c) begin
            m_r       = 1'b1;
            m_pressed = 1'b0;
        end else begin
            d = cyc - m_pedge;
            if (d == LONG) m_l = 1'b1;
            else if (d > LONG && (d - LONG) % RPT == 0) m_rp = 1'b1;
        end
        m_h = m_pressed;
        #1;
        act = {bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse,
               bus.held, bus.press_count};
        exp = {m_p, m_r, m_l, m_rp, m_h, 8'(m_count)};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL outs cyc=%0d got p/r/l/rp/h/cnt=%b/%b/%b/%b/%b/%0d want %b/%b/%b/%b/%b/%0d",
                     cyc, act[12], act[11], act[10], act[9], act[8], act[7:0],
                     exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
        if (bus.press_pulse === 1'b1)   begin n_press++; press_e = cyc; end
        if (bus.release_pulse === 1'b1) begin n_rel++;   rel_e   = cyc; end
        if (bus.long_pulse === 1'b1)    begin n_long++;  long_e  = cyc; end
        if (bus.repeat_pulse === 1'b1)  begin n_rep++;   rep_q.push_back(cyc); end
    endtask

    initial begin
        int nl, nr, np, nrp, p6;
        bus.clean = 1'b0;

        // 1: reset with clean low
        repeat (3) tick(1'b0, 1'b1);
        chk("rst_held", int'(bus.held), 0);
        chk("rst_count", int'(bus.press_count), 0);
        chk("rst_pulses", int'({bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse}), 0);
        repeat (2) tick(1'b0, 1'b0);

        // 2: short hold of 8 cycles
        nl = n_long;
        repeat (8) tick(1'b1, 1'b0);
        repeat (4) tick(1'b0, 1'b0);
        chk("s2_release_ofs", rel_e - press_e, 8);
        chk("s2_no_long", n_long - nl, 0);
        chk("s2_count", int'(bus.press_count), 1);

        // 3: 30-cycle hold, long then repeats
        rep_q.delete();
        nl = n_long;
        repeat (30) tick(1'b1, 1'b0);
        repeat (4) tick(1'b0, 1'b0);
        chk("s3_long_cnt", n_long - nl, 1);
        chk("s3_long_ofs", long_e - press_e, 16);
        chk("s3_rep_cnt", rep_q.size(), 3);
        if (rep_q.size() == 3) begin
            chk("s3_rep0_ofs", rep_q[0] - press_e, 20);
            chk("s3_rep1_ofs", rep_q[1] - press_e, 24);
            chk("s3_rep2_ofs", rep_q[2] - press_e, 28);
        end
        chk("s3_release_ofs", rel_e - press_e, 30);

        // 4: release on the edge long would fire
        nl = n_long; nrp = n_rep;
        repeat (16) tick(1'b1, 1'b0);
        repeat (4) tick(1'b0, 1'b0);
        chk("s4_release_ofs", rel_e - press_e, 16);
        chk("s4_no_long", n_long - nl, 0);
        chk("s4_no_rep", n_rep - nrp, 0);

        // 5: 257 one-cycle presses from a fresh count
        repeat (2) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        np = n_press; nr = n_rel; nl = n_long;
        repeat (257) begin
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
        end
        chk("s5_count_wrap", int'(bus.press_count), 1);
        chk("s5_model_count", m_count, 1);
        chk("s5_presses", n_press - np, 257);
        chk("s5_releases", n_rel - nr, 257);
        chk("s5_no_long", n_long - nl, 0);

        // 6: clean high through reset, then reset mid-hold
        repeat (3) tick(1'b1, 1'b1);
        np = n_press;
        tick(1'b1, 1'b0);
        p6 = cyc;
        chk("s6_press_now", n_press - np, 1);
        chk("s6_press_edge", press_e, p6);
        repeat (6) tick(1'b1, 1'b0);
        nr = n_rel;
        tick(1'b1, 1'b1);
        chk("s6_rst_held", int'(bus.held), 0);
        chk("s6_rst_count", int'(bus.press_count), 0);
        chk("s6_rst_pulses", int'({bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse}), 0);
        tick(1'b0, 1'b1);
        repeat (3) tick(1'b0, 1'b0);
        chk("s6_no_release", n_rel - nr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
